// File: rtl/spi_master_multichan.sv
// spi_master_multichan
//
// SPI master (mode 0) that moves NCH words of DW bits each in one frame per
// rising edge of the asynchronous SIMCK trigger. Full duplex: the same number
// of bits is captured from MISO and presented on rx_data at frame end.
// Word NCH-1 goes first on the wire, MSB first; receive order mirrors it.
//
// Optional feature, enabled by defining SPI_CRC8_TRAILER_EN:
//   an 8-bit CRC-8 trailer (poly 0x07, init 0x00, MSB first over all data
//   bits) follows the data bits. The peer's trailer is checked against the
//   CRC of the received data and the result appears on crc_err.
//
// Ports
//   clk       system clock
//   reset     active-low synchronous reset
//   clkdiv    SCK half-period minus one, in clk cycles
//   en        frame enable; gates new frames only
//   SIMCK     asynchronous frame trigger (rising edge)
//   tx_data   words to send, word 0 at [DW-1:0]
//   DATA_IN   MISO
//   SCK       serial clock, idle low
//   SSEL      slave select, active low
//   DATA_OUT  MOSI
//   rx_data   last complete received frame, word 0 at [DW-1:0]
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      high from SETUP through GAP
//   overrun   sticky; a trigger arrived while busy
//   frame_cnt completed frames, wraps
//   crc_err   (feature build only) trailer mismatch, updated with rx_valid
//
// Handshake: rx_valid is a one-cycle strobe with no ready; rx_data is stable
// from the rx_valid cycle until the next rx_valid or reset.
module spi_master_multichan #(
  parameter int NCH = 2,
  parameter int DW  = 32,
  parameter int CDW = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CDW-1:0]    clkdiv,
  input  logic              en,
  input  logic              SIMCK,
  input  logic [NCH*DW-1:0] tx_data,
  input  logic              DATA_IN,
  output logic              SCK,
  output logic              SSEL,
  output logic              DATA_OUT,
  output logic [NCH*DW-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_cnt
`ifdef SPI_CRC8_TRAILER_EN
  ,
  output logic              crc_err
`endif
);

  localparam int DBITS = NCH * DW;
`ifdef SPI_CRC8_TRAILER_EN
  localparam int TBITS = DBITS + 8;
`else
  localparam int TBITS = DBITS;
`endif
  // SHIFT spans two half-periods per bit.
  localparam int NHP = 2 * TBITS;
  localparam int HPW = $clog2(NHP + 1);
  localparam logic [HPW-1:0] LAST_HP = HPW'(NHP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CDW-1:0]     div_q, div_d;
  logic [HPW-1:0]     hp_q, hp_d;
  logic [TBITS-1:0]   tx_sr_q, tx_sr_d;
  logic [TBITS-1:0]   rx_sr_q, rx_sr_d;
  logic               sck_q, sck_d;
  logic               ssel_q, ssel_d;
  logic               mosi_q, mosi_d;
  logic [DBITS-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic               tick_q, tick_d;
`ifdef SPI_CRC8_TRAILER_EN
  logic               crc_err_q, crc_err_d;
`endif

  logic               hp_end;
  logic [TBITS-1:0]   tx_load;

`ifdef SPI_CRC8_TRAILER_EN
  function automatic logic [7:0] crc8_bits(input logic [DBITS-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = DBITS - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  // Frame image as it goes on the wire, trailer (if any) in the low byte.
  always_comb begin
`ifdef SPI_CRC8_TRAILER_EN
    tx_load = {tx_data, crc8_bits(tx_data)};
`else
    tx_load = tx_data;
`endif
  end

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    sck_d       = sck_q;
    ssel_d      = ssel_q;
    mosi_d      = mosi_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
`ifdef SPI_CRC8_TRAILER_EN
    crc_err_d   = crc_err_q;
`endif

    // Two-flop synchroniser followed by a registered rising-edge detect.
    s1_d   = SIMCK;
    s2_d   = s1_q;
    s3_d   = s2_q;
    tick_d = s2_q & ~s3_q;

    // Half-period timer: clkdiv is re-sampled on every reload, and held
    // at the reload value while idle so SETUP starts with a full count.
    hp_end = (div_q == '0);
    div_d  = (state_q == ST_IDLE || hp_end) ? clkdiv : div_q - 1'b1;

    // busy_q is still high in the cycle GAP exits, so a trigger there is
    // dropped as an overrun rather than starting a frame.
    if (tick_q && busy_q) overrun_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (tick_q && en) begin
          tx_sr_d = tx_load;
          rx_sr_d = '0;
          mosi_d  = tx_load[TBITS-1];
          ssel_d  = 1'b0;
          busy_d  = 1'b1;
          hp_d    = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (hp_end) begin
          // First SCK rise: sample MISO into the LSB.
          sck_d   = 1'b1;
          rx_sr_d = (rx_sr_q << 1) | TBITS'(DATA_IN);
          hp_d    = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (hp_end) begin
          hp_d = hp_q + 1'b1;
          if (hp_q == LAST_HP) begin
            // Final low half-period done after the last fall.
            state_d = ST_HOLD;
          end else if (!hp_q[0]) begin
            // SCK fall: advance and present the next bit.
            sck_d   = 1'b0;
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_d[TBITS-1];
          end else begin
            // SCK rise: capture MISO.
            sck_d   = 1'b1;
            rx_sr_d = (rx_sr_q << 1) | TBITS'(DATA_IN);
          end
        end
      end
      ST_HOLD: begin
        if (hp_end) begin
          ssel_d      = 1'b1;
          rx_data_d   = rx_sr_q[TBITS-1 -: DBITS];
          rx_valid_d  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef SPI_CRC8_TRAILER_EN
          crc_err_d   = (crc8_bits(rx_sr_q[TBITS-1 -: DBITS]) != rx_sr_q[7:0]);
`endif
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (hp_end) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      hp_q        <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      tick_q      <= 1'b0;
`ifdef SPI_CRC8_TRAILER_EN
      crc_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hp_q        <= hp_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      sck_q       <= sck_d;
      ssel_q      <= ssel_d;
      mosi_q      <= mosi_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      tick_q      <= tick_d;
`ifdef SPI_CRC8_TRAILER_EN
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  assign SCK       = sck_q;
  assign SSEL      = ssel_q;
  assign DATA_OUT  = mosi_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;
`ifdef SPI_CRC8_TRAILER_EN
  assign crc_err   = crc_err_q;
`endif

endmodule

// File: tb/tb_spi_master_multichan.sv
// Bench for spi_master_multichan: dut_a is the 2x32-bit link with MOSI looped
// to MISO, dut_b the 1x8-bit divider-corner/CRC instance (MISO = MOSI ^ flip_b).
module tb_spi_master_multichan;

`ifdef SPI_CRC8_TRAILER_EN
  localparam int TRAIL = 8;
`else
  localparam int TRAIL = 0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Stimulus signals
  logic [23:0] clkdiv_a, clkdiv_b;
  logic        en_a, en_b, simck_a, simck_b, flip_b;
  logic [63:0] tx_a;
  logic [7:0]  tx_b;

  // DUT outputs
  logic        sck_a, ssel_a, data_out_a, rx_valid_a, busy_a, overrun_a;
  logic [63:0] rx_data_a;
  logic [15:0] frame_cnt_a;
  logic        sck_b, ssel_b, data_out_b, rx_valid_b, busy_b, overrun_b;
  logic [7:0]  rx_data_b;
  logic [15:0] frame_cnt_b;
`ifdef SPI_CRC8_TRAILER_EN
  logic        crc_err_a, crc_err_b;
`endif
  logic        data_in_a, data_in_b;

  assign data_in_a = data_out_a;
  assign data_in_b = data_out_b ^ flip_b;

  spi_master_multichan #(.NCH(2), .DW(32), .CDW(24)) dut_a (
    .clk(clk), .reset(reset), .clkdiv(clkdiv_a), .en(en_a), .SIMCK(simck_a),
    .tx_data(tx_a), .DATA_IN(data_in_a), .SCK(sck_a), .SSEL(ssel_a),
    .DATA_OUT(data_out_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .busy(busy_a), .overrun(overrun_a), .frame_cnt(frame_cnt_a)
`ifdef SPI_CRC8_TRAILER_EN
    , .crc_err(crc_err_a)
`endif
  );

  spi_master_multichan #(.NCH(1), .DW(8), .CDW(24)) dut_b (
    .clk(clk), .reset(reset), .clkdiv(clkdiv_b), .en(en_b), .SIMCK(simck_b),
    .tx_data(tx_b), .DATA_IN(data_in_b), .SCK(sck_b), .SSEL(ssel_b),
    .DATA_OUT(data_out_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .busy(busy_b), .overrun(overrun_b), .frame_cnt(frame_cnt_b)
`ifdef SPI_CRC8_TRAILER_EN
    , .crc_err(crc_err_b)
`endif
  );

  // Counters and checker
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues
  logic [0:0]  bit_q_a[$];
  logic [0:0]  bit_q_b[$];
  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
`ifdef SPI_CRC8_TRAILER_EN
  logic [0:0]  crc_q_b[$];

  function automatic logic [7:0] crc8_model(input logic [63:0] d, input int nbits);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction
`endif

  task automatic push_a(input logic [63:0] tx);
    for (int i = 63; i >= 0; i--) bit_q_a.push_back(tx[i]);
`ifdef SPI_CRC8_TRAILER_EN
    begin
      logic [7:0] c;
      c = crc8_model(tx, 64);
      for (int i = 7; i >= 0; i--) bit_q_a.push_back(c[i]);
    end
`endif
    exp_q_a.push_back(tx);
  endtask

  task automatic push_b(input logic [7:0] tx, input logic [7:0] rx_exp, input logic crc_exp);
    for (int i = 7; i >= 0; i--) bit_q_b.push_back(tx[i]);
`ifdef SPI_CRC8_TRAILER_EN
    begin
      logic [7:0] c;
      c = crc8_model({56'd0, tx}, 8);
      for (int i = 7; i >= 0; i--) bit_q_b.push_back(c[i]);
    end
    crc_q_b.push_back(crc_exp);
`else
    if (crc_exp) exp_q_b.push_back(64'd0);
`endif
    exp_q_b.push_back({56'd0, rx_exp});
  endtask

  // Monitors (sample on the falling edge)
  int   rises_a = 0, valids_a = 0, ssel_low_a = 0, busy_len_a = 0;
  int   rises_b = 0, valids_b = 0, busy_len_b = 0, cyc_b = 0, last_rise_b = 0;
  logic sck_a_prev = 1'b0, sck_b_prev = 1'b0, have_rise_b = 1'b0;

  always @(negedge clk) begin
    if (sck_a === 1'b1 && sck_a_prev === 1'b0) begin
      rises_a++;
      if (bit_q_a.size() > 0) check("mosi_a", 64'(data_out_a), 64'(bit_q_a.pop_front()));
      else check("sck_rise_unexpected_a", 64'(sck_a), 64'd0);
    end
    if (ssel_a === 1'b0) ssel_low_a++;
    if (busy_a === 1'b1) busy_len_a++;
    if (rx_valid_a === 1'b1) begin
      valids_a++;
      if (exp_q_a.size() > 0) check("rx_data_a", rx_data_a, exp_q_a.pop_front());
      else check("rx_valid_unexpected_a", 64'(rx_valid_a), 64'd0);
`ifdef SPI_CRC8_TRAILER_EN
      check("crc_err_a", 64'(crc_err_a), 64'd0);
`endif
    end
    sck_a_prev = sck_a;
  end

  always @(negedge clk) begin
    cyc_b++;
    if (sck_b === 1'b1 && sck_b_prev === 1'b0) begin
      rises_b++;
      if (have_rise_b) check("sck_period_b", 64'(cyc_b - last_rise_b), 64'((int'(clkdiv_b) + 1) * 2));
      have_rise_b = 1'b1;
      last_rise_b = cyc_b;
      if (bit_q_b.size() > 0) check("mosi_b", 64'(data_out_b), 64'(bit_q_b.pop_front()));
      else check("sck_rise_unexpected_b", 64'(sck_b), 64'd0);
    end
    if (ssel_b === 1'b1) have_rise_b = 1'b0;
    if (busy_b === 1'b1) busy_len_b++;
    if (rx_valid_b === 1'b1) begin
      valids_b++;
      if (exp_q_b.size() > 0) check("rx_data_b", 64'(rx_data_b), exp_q_b.pop_front());
      else check("rx_valid_unexpected_b", 64'(rx_valid_b), 64'd0);
`ifdef SPI_CRC8_TRAILER_EN
      if (crc_q_b.size() > 0) check("crc_err_b", 64'(crc_err_b), 64'(crc_q_b.pop_front()));
`endif
    end
    sck_b_prev = sck_b;
  end

  // Driver tasks (called at a falling edge)
  task automatic pulse_a();
    simck_a = 1'b1;
    repeat (4) @(negedge clk);
    simck_a = 1'b0;
  endtask

  // Raise SIMCK and confirm SSEL falls exactly on the third edge after the
  // first synchroniser flop sees it.
  task automatic start_a();
    simck_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ssel_latency_pre_a", 64'(ssel_a), 64'd1);
    end
    @(negedge clk);
    check("ssel_latency_a", 64'(ssel_a), 64'd0);
    simck_a = 1'b0;
  endtask

  task automatic start_b();
    simck_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ssel_latency_pre_b", 64'(ssel_b), 64'd1);
    end
    @(negedge clk);
    check("ssel_latency_b", 64'(ssel_b), 64'd0);
    simck_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int i = 0;
    while (busy_a === 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("timeout_busy_a", 64'(busy_a), 64'd0);
  endtask

  task automatic wait_idle_b(input int budget);
    int i = 0;
    while (busy_b === 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("timeout_busy_b", 64'(busy_b), 64'd0);
  endtask

  // Directed sequence
  initial begin
    int exp_len;
    int i;
    reset    = 1'b0;
    clkdiv_a = 24'd13;
    clkdiv_b = 24'd0;
    en_a     = 1'b1;
    en_b     = 1'b1;
    simck_a  = 1'b0;
    simck_b  = 1'b0;
    flip_b   = 1'b0;
    tx_a     = 64'h3F666666_42A00000;
    tx_b     = 8'hA5;

    // Reset held 5 cycles with SIMCK toggling
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      simck_a = ~simck_a;
      simck_b = ~simck_b;
      check("rst_rx_valid_a", 64'(rx_valid_a), 64'd0);
    end
    check("rst_ssel_a", 64'(ssel_a), 64'd1);
    check("rst_sck_a", 64'(sck_a), 64'd0);
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_frame_cnt_a", 64'(frame_cnt_a), 64'd0);
    check("rst_overrun_a", 64'(overrun_a), 64'd0);
    check("rst_data_out_a", 64'(data_out_a), 64'd0);
    check("rst_rx_data_a", rx_data_a, 64'd0);
    check("rst_ssel_b", 64'(ssel_b), 64'd1);
    check("rst_frame_cnt_b", 64'(frame_cnt_b), 64'd0);
    simck_a = 1'b0;
    simck_b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy_a", 64'(busy_a), 64'd0);

    // en low blocks new frames
    en_a = 1'b0;
    pulse_a();
    repeat (10) @(negedge clk);
    check("en_low_busy_a", 64'(busy_a), 64'd0);
    check("en_low_ssel_a", 64'(ssel_a), 64'd1);
    check("en_low_overrun_a", 64'(overrun_a), 64'd0);
    en_a = 1'b1;

    // Single frame, loopback
    rises_a = 0; valids_a = 0; ssel_low_a = 0; busy_len_a = 0;
    push_a(tx_a);
    start_a();
    tx_a = 64'hDEADBEEF_01234567;  // after the latch: must not disturb the frame
    wait_idle_a(6000);
    check("rises_a", 64'(rises_a), 64'(64 + TRAIL));
    check("valids_a", 64'(valids_a), 64'd1);
    check("frame_cnt_a_1", 64'(frame_cnt_a), 64'd1);
    exp_len = 14 * (2 * (64 + TRAIL) + 2);
    check("ssel_low_len_a",
          64'((ssel_low_a >= exp_len - 1 && ssel_low_a <= exp_len + 1) ? exp_len : ssel_low_a),
          64'(exp_len));
    check("busy_len_a", 64'(busy_len_a), 64'(14 * (2 * (64 + TRAIL) + 3)));
    check("overrun_single_a", 64'(overrun_a), 64'd0);
    check("idle_sck_a", 64'(sck_a), 64'd0);

    // Overrun: second rise 200 cycles after the first
    repeat (5) @(negedge clk);
    tx_a = {$urandom(), $urandom()};
    valids_a = 0;
    push_a(tx_a);
    start_a();
    repeat (196) @(negedge clk);
    check("busy_at_second_rise_a", 64'(busy_a), 64'd1);
    pulse_a();
    check("overrun_set_a", 64'(overrun_a), 64'd1);
    wait_idle_a(6000);
    repeat (10) @(negedge clk);
    check("no_queued_frame_a", 64'(busy_a), 64'd0);
    check("frame_cnt_a_2", 64'(frame_cnt_a), 64'd2);
    check("valids_overrun_a", 64'(valids_a), 64'd1);
    tx_a = {$urandom(), $urandom()};
    push_a(tx_a);
    start_a();
    wait_idle_a(6000);
    check("frame_cnt_a_3", 64'(frame_cnt_a), 64'd3);
    check("overrun_sticky_a", 64'(overrun_a), 64'd1);
    check("valids_third_a", 64'(valids_a), 64'd2);

    // Reset mid-frame at SCK rise 40
    repeat (5) @(negedge clk);
    tx_a = {$urandom(), $urandom()};
    rises_a = 0; valids_a = 0;
    push_a(tx_a);
    start_a();
    i = 0;
    while (rises_a < 40 && i < 4000) begin
      @(negedge clk);
      i++;
    end
    check("rise40_reached_a", 64'(rises_a), 64'd40);
    reset = 1'b0;
    bit_q_a.delete();
    exp_q_a.delete();
    @(negedge clk);
    check("abort_ssel_a", 64'(ssel_a), 64'd1);
    check("abort_rx_valid_a", 64'(rx_valid_a), 64'd0);
    check("abort_rx_data_a", rx_data_a, 64'd0);
    check("abort_frame_cnt_a", 64'(frame_cnt_a), 64'd0);
    check("abort_busy_a", 64'(busy_a), 64'd0);
    check("abort_sck_a", 64'(sck_a), 64'd0);
    check("abort_overrun_a", 64'(overrun_a), 64'd0);
    reset = 1'b1;
    repeat (2500) @(negedge clk);
    check("abort_no_valid_a", 64'(valids_a), 64'd0);
    check("abort_idle_a", 64'(busy_a), 64'd0);

    // Divider corner: clkdiv=0, 1x8 bits, frame counter wrap
    force dut_b.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_b.frame_cnt_q;
    @(negedge clk);
    check("preload_frame_cnt_b", 64'(frame_cnt_b), 64'hFFFF);
    rises_b = 0; valids_b = 0; busy_len_b = 0;
    push_b(8'hA5, 8'hA5, 1'b0);
    start_b();
    wait_idle_b(500);
    check("rises_b", 64'(rises_b), 64'(8 + TRAIL));
    check("valids_b", 64'(valids_b), 64'd1);
    check("wrap_frame_cnt_b", 64'(frame_cnt_b), 64'd0);
    check("busy_len_b", 64'(busy_len_b), 64'(2 * (8 + TRAIL) + 3));

`ifdef SPI_CRC8_TRAILER_EN
    // CRC trailer: zero data, clean loopback
    repeat (5) @(negedge clk);
    clkdiv_b = 24'd3;
    tx_b = 8'h00;
    busy_len_b = 0;
    push_b(8'h00, 8'h00, 1'b0);
    start_b();
    wait_idle_b(1000);
    check("crc_busy_len_b", 64'(busy_len_b), 64'(4 * (2 * (8 + 8) + 3)));
    check("crc_clean_err_b", 64'(crc_err_b), 64'd0);

    // One MISO bit flipped on the fourth rise
    repeat (5) @(negedge clk);
    rises_b = 0;
    push_b(8'h00, 8'h10, 1'b1);
    start_b();
    i = 0;
    while (rises_b < 3 && i < 500) begin @(negedge clk); i++; end
    while (sck_b === 1'b1 && i < 500) begin @(negedge clk); i++; end
    flip_b = 1'b1;
    while (rises_b < 4 && i < 500) begin @(negedge clk); i++; end
    flip_b = 1'b0;
    check("flip_rise_reached_b", 64'(rises_b), 64'd4);
    wait_idle_b(1000);
    check("crc_flip_err_b", 64'(crc_err_b), 64'd1);

    // Clean again clears crc_err
    repeat (5) @(negedge clk);
    tx_b = 8'h3C;
    push_b(8'h3C, 8'h3C, 1'b0);
    start_b();
    wait_idle_b(1000);
    check("crc_reclean_err_b", 64'(crc_err_b), 64'd0);
    check("crc_frame_cnt_b", 64'(frame_cnt_b), 64'd3);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty_a", 64'(exp_q_a.size()), 64'd0);
    check("sb_empty_b", 64'(exp_q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_multichan.md
Name: spi_master_multichan

Overview:
- Parametrised successor to the single-word `spi_master` used per muscle channel.
- Serialises NCH data words of DW bits each into one SPI frame, triggered by each rising edge of the simulation clock. Full-duplex: captures the same number of MISO words from the peer board in the same frame.
- Lets one link carry several channels per frame, e.g. biceps and triceps Ia/II firing rates, in place of one master per channel.
- Sits between the spindle/neuron outputs and the board-to-board header pins.

Parameters:
- NCH, 2, number of data words per frame (1..16).
- DW, 32, bits per word.
- CDW, 24, width of the clkdiv input.

Ports:
- clk  input  1  system clock (clk1 domain).
- reset  input  1  active-low, synchronous reset.
- clkdiv  input  CDW  SCK half-period minus one, in clk cycles.
- en  input  1  frame enable; when low, ticks are ignored.
- SIMCK  input  1  asynchronous frame trigger; each rising edge requests one frame.
- tx_data  input  NCH*DW  words to send; word 0 is at bits [DW-1:0].
- DATA_IN  input  1  MISO from peer.
- SCK  output  1  serial clock, idle low.
- SSEL  output  1  slave select, active low.
- DATA_OUT  output  1  MOSI.
- rx_data  output  NCH*DW  last complete received frame; word 0 at [DW-1:0].
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high from SETUP through GAP.
- overrun  output  1  sticky; a tick arrived while busy.
- frame_cnt  output  16  completed frames, wraps 0xFFFF->0.

Behaviour:
- Reset (reset==0 at a clk edge): all state clears in that cycle.
  - SCK=0, SSEL=1, DATA_OUT=0, rx_data=0, rx_valid=0, busy=0, overrun=0, frame_cnt=0.
  - State goes to IDLE and the SIMCK synchroniser clears.
- Reset mid-frame aborts immediately:
  - SSEL goes high on the next edge.
  - No rx_valid pulse; partial rx is discarded.
- SIMCK handling:
  - Passes through a 2-flop synchroniser, then a registered rising-edge detect, giving `tick`.
  - SSEL falls 3 clk cycles after the SIMCK rise crosses the first flop.
- Half-period timer: divider counter reloads to clkdiv. A half-period is clkdiv+1 clk cycles.
- States:
  - IDLE: on tick && en, latch tx_data into the shift register, clear the rx shift register, SSEL=0, busy=1, go to SETUP.
  - SETUP: DATA_OUT = MSB of word NCH-1 (the highest word goes first, MSB first). Wait one half-period, then go to SHIFT.
  - SHIFT: 2*NCH*DW half-periods, SPI mode 0.
    - At each SCK rise, sample DATA_IN into the rx shift register LSB.
    - At each SCK fall, shift tx and present the next bit.
    - After the last fall, SCK=0 and go to HOLD.
  - HOLD: wait one half-period, then SSEL=1.
    - Copy the rx shift register to rx_data; rx_valid=1 for exactly one cycle.
    - frame_cnt+=1, go to GAP.
  - GAP: wait one half-period, then busy=0 and go to IDLE.
- Received word order mirrors transmit: the first NCH-1 word received lands in rx_data word NCH-1.
- tx_data changes after the latch do not affect the frame in flight.
- A tick while busy is dropped (no queueing) and sets overrun. Overrun clears only on reset.
- A tick in the same cycle that GAP exits to IDLE counts as busy: it is dropped and sets overrun.
- en low mid-frame does not abort; it only blocks new frames.
- clkdiv is sampled at each timer reload; changes take effect from the next half-period.
- Frame length in clk cycles = (clkdiv+1)*(2*NCH*DW+3).

Optional Feature:
- Macro: SPI_CRC8_TRAILER_EN.
- When defined:
  - After the last data bit, an 8-bit CRC-8 (poly 0x07, init 0x00, computed MSB-first over all transmitted bits) is sent as 8 extra SCK cycles before HOLD.
  - The peer's 8 trailer bits are checked against CRC-8 of the received data.
  - Adds output crc_err (1 bit), registered and updated with the same timing as rx_valid. crc_err=1 on mismatch, and rx_data still updates.
  - Frame length becomes (clkdiv+1)*(2*(NCH*DW+8)+3).
- When undefined:
  - No trailer bits are sent or received.
  - The crc_err port does not exist.

Test Plan:
- Reset: hold reset=0 for 5 cycles with SIMCK toggling -> SSEL=1, SCK=0, busy=0, frame_cnt=0, no rx_valid.
- Single frame: NCH=2, DW=32, clkdiv=13, tx_data={32'h3F666666, 32'h42A00000}, DATA_OUT looped back to DATA_IN, one SIMCK rise:
  - 128 SCK rises; MOSI bit sequence equals 0x3F666666 then 0x42A00000, MSB first.
  - rx_data == tx_data, rx_valid pulses once, frame_cnt=1.
  - SSEL-low duration = 14*131 - 14 cycles (±1).
- Overrun: clkdiv=13, second SIMCK rise 200 cycles after the first -> second frame not started, overrun=1, frame_cnt=1 after completion. A third rise after busy=0 -> frame_cnt=2, overrun still 1.
- Reset mid-frame: assert reset=0 at SCK rise 40 -> SSEL=1 next cycle, no rx_valid, rx_data=0, frame_cnt=0.
- Divider corner: clkdiv=0, NCH=1, DW=8, tx_data=8'hA5 -> SCK period 2 clk cycles, MOSI 1010_0101, frame_cnt wraps 0xFFFF->0 when preloaded via force.
- CRC (SPI_CRC8_TRAILER_EN): NCH=1, DW=8, tx 0x00 -> trailer 0x00. Inject a flipped MISO bit -> crc_err=1 with rx_valid; clean loopback -> crc_err=0.
